// File: rtl/clk_div_n_if.sv
// ---------------------------------------------------------------------------
// clk_div_n_if
//   Bundles the control and status signals of the clk_div_n divider so the
//   block can be instantiated with a single port. The clock (ck) and reset
//   (rs) stay as plain ports on the module.
//
//   en    master->slave  count enable; low freezes the divider
//   load  master->slave  one-cycle request to change the divisor
//   div   master->slave  requested divisor N, sampled when load=1
//   f     slave->master  divided clock, 50% duty for odd and even N
//   tick  slave->master  one-cycle pulse at the start of each output period
//   cnt   slave->master  current phase counter, 0..N-1
//   busy  slave->master  an accepted divisor change is still pending
//   err   slave->master  one-cycle pulse when a load is rejected
// ---------------------------------------------------------------------------
interface clk_div_n_if #(
    parameter int W = 8
) ();
    logic         en;
    logic         load;
    logic [W-1:0] div;
    logic         f;
    logic         tick;
    logic [W-1:0] cnt;
    logic         busy;
    logic         err;

    modport master (
        output en,
        output load,
        output div,
        input  f,
        input  tick,
        input  cnt,
        input  busy,
        input  err
    );

    modport slave (
        input  en,
        input  load,
        input  div,
        output f,
        output tick,
        output cnt,
        output busy,
        output err
    );
endinterface

// File: rtl/clk_div_n.sv
// ---------------------------------------------------------------------------
// clk_div_n
//   Programmable integer clock divider with 50% duty cycle for both odd and
//   even divisors. The divisor can be changed at run time; a new value is
//   held pending and only takes effect at the next wrap of the phase
//   counter, so the output never shows a runt pulse.
//
//   Parameters
//     W        width of the divisor and phase counter
//     DIV_DEF  divisor applied at reset (2..2^W-1)
//
//   Ports
//     ck   sole clock; everything updates on the rising edge except the
//          half-cycle duty-correction flop, which updates on the falling edge
//     rs   synchronous active-high reset
//     bus  clk_div_n_if slave modport (en, load, div in; f, tick, cnt, busy,
//          err out)
// ---------------------------------------------------------------------------
module clk_div_n #(
    parameter int W       = 8,
    parameter int DIV_DEF = 3
) (
    input  logic       ck,
    input  logic       rs,
    clk_div_n_if.slave bus
);

    localparam logic [W-1:0] DIV_RST = W'(DIV_DEF);
    localparam logic [W-1:0] ONE     = W'(1);

    // ceil(d/2): number of counter phases for which the rising-edge flop is
    // high. Widened by one bit so d = 2^W-1 does not overflow.
    function automatic logic [W:0] half_ceil(input logic [W-1:0] d);
        logic [W:0] t;
        t = {1'b0, d} + {{W{1'b0}}, 1'b1};
        return t >> 1;
    endfunction

    // Divisors below 2 cannot produce a divided clock and are rejected.
    function automatic logic div_ok(input logic [W-1:0] d);
        return d >= W'(2);
    endfunction

    // Architectural state
    logic [W-1:0] div_q;
    logic         odd_q;
    logic [W-1:0] pend;
    logic         pend_v;
    logic [W-1:0] cnt_q;
    logic         f_p;
    logic         f_n;
    logic         tick_q;
    logic         err_q;

    // Next-state terms
    logic         last;
    logic         wrap;
    logic         apply;
    logic [W-1:0] div_nx;
    logic [W-1:0] cnt_nx;
    logic         fp_nx;
    logic         ld_ok;
    logic         ld_bad;

    always_comb begin
        last   = (cnt_q == (div_q - ONE));
        // Wrap edges only happen while enabled, so a pending divisor waits
        // out any stall.
        wrap   = bus.en && last;
        // Only a divisor that was already pending before this edge is
        // applied; a load on the wrap edge itself lands in pend for the
        // following period.
        apply  = wrap && pend_v;
        div_nx = apply ? pend : div_q;
        cnt_nx = wrap ? '0 : (cnt_q + ONE);
        // Uses the divisor in force after the edge so the first period of a
        // new divisor already has the correct high phase.
        fp_nx  = ({1'b0, cnt_nx} < half_ceil(div_nx));
        ld_ok  = bus.load && div_ok(bus.div);
        ld_bad = bus.load && !div_ok(bus.div);
    end

    // Rising-edge stage: counter, divisor bookkeeping, tick and error pulses
    always_ff @(posedge ck) begin
        if (rs) begin
            div_q  <= DIV_RST;
            odd_q  <= DIV_RST[0];
            // Parked on the last phase so the first enabled edge wraps.
            cnt_q  <= DIV_RST - ONE;
            f_p    <= 1'b0;
            tick_q <= 1'b0;
            pend   <= '0;
            pend_v <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tick_q <= wrap;
            err_q  <= ld_bad;

            if (bus.en) begin
                cnt_q <= cnt_nx;
                f_p   <= fp_nx;
            end

            if (apply) begin
                div_q <= pend;
                odd_q <= pend[0];
            end

            // A fresh request always wins over clearing the one just
            // applied, so a load on the wrap edge stays pending.
            if (ld_ok) begin
                pend   <= bus.div;
                pend_v <= 1'b1;
            end else if (apply) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Falling-edge stage: half-cycle delayed copy of f_p. No reset needed;
    // f_p is 0 during reset, so this reads 0 by the first falling edge.
    always_ff @(negedge ck) begin
        f_n <= f_p;
    end

    // For odd N, ANDing with the half-cycle delayed copy trims half a ck
    // period off the high phase, giving (N-1)/2+0.5 high and low.
    assign bus.f    = odd_q ? (f_p & f_n) : f_p;
    assign bus.tick = tick_q;
    assign bus.cnt  = cnt_q;
    assign bus.busy = pend_v;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_clk_div_n.sv
// ---------------------------------------------------------------------------
// tb_clk_div_n
//   Directed, table-driven bench for clk_div_n (W=8, DIV_DEF=3). Each record
//   holds the inputs for one ck cycle and the expected outputs after the
//   rising edge (cnt, tick, busy, err, f) and after the following falling
//   edge (f). Reset behaviour is exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_clk_div_n;

    localparam int W = 8;

    logic ck;
    logic rs;

    clk_div_n_if #(.W(W)) bus ();

    clk_div_n #(.W(W), .DIV_DEF(3)) dut (
        .ck  (ck),
        .rs  (rs),
        .bus (bus.slave)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic         rs;
        logic         en;
        logic         load;
        logic [W-1:0] div;
        logic [W-1:0] cnt;
        logic         tick;
        logic         busy;
        logic         err;
        logic         fa;
        logic         fb;
    } vec_t;

    vec_t vt[$];
    int   n_run;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic l, input int d,
                       input int c, input logic t, input logic b, input logic er,
                       input logic fa, input logic fb);
        vec_t v;
        v.rs   = r;
        v.en   = e;
        v.load = l;
        v.div  = W'(d);
        v.cnt  = W'(c);
        v.tick = t;
        v.busy = b;
        v.err  = er;
        v.fa   = fa;
        v.fb   = fb;
        vt.push_back(v);
    endtask

    // Drive one cycle (called just after a falling edge), then check the
    // outputs shortly after the rising edge and again after the falling edge.
    task automatic apply_vec(input string tag, input vec_t v);
        rs       = v.rs;
        bus.en   = v.en;
        bus.load = v.load;
        bus.div  = v.div;
        @(posedge ck);
        #1;
        chk({tag, ".cnt"},  32'(bus.cnt),  32'(v.cnt));
        chk({tag, ".tick"}, 32'(bus.tick), 32'(v.tick));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(v.busy));
        chk({tag, ".err"},  32'(bus.err),  32'(v.err));
        chk({tag, ".f_hi"}, 32'(bus.f),    32'(v.fa));
        @(negedge ck);
        #1;
        chk({tag, ".f_lo"}, 32'(bus.f),    32'(v.fb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        n_run    = 0;
        n_fail   = 0;
        rs       = 1'b1;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.div  = '0;

        //   rs en ld div  cnt tk bs er fa fb
        // N=3 from reset: 0,1,2 cadence, f 1.5 high / 1.5 low
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        // load 4 mid-period; busy until the next wrap, then 2 high / 2 low
        add(0, 1, 1, 4,   1, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   3, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   3, 0, 0, 0, 0, 0);
        // load 5 on a wrap edge: this period stays N=4, next is 2.5 / 2.5
        add(0, 1, 1, 5,   0, 1, 1, 0, 1, 1);
        add(0, 1, 0, 0,   1, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0,   3, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   3, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   4, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        // rejected loads (1 and 0): err pulse, cadence and busy unchanged
        add(0, 1, 1, 1,   1, 0, 0, 1, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0,   3, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0,   4, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        // en low for 4 cycles at cnt=1: frozen, no tick, resume at 2
        add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   3, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   4, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        // load 6 then 7 (last wins), with a stall while pending
        add(0, 1, 1, 6,   1, 0, 1, 0, 1, 1);
        add(0, 1, 1, 7,   2, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0,   2, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0,   3, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0,   4, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   3, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   4, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   5, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   6, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);

        // Reset state: hold rs for a few cycles with en and load asserted.
        bus.en   = 1'b1;
        bus.load = 1'b1;
        bus.div  = W'(9);
        repeat (3) @(posedge ck);
        #1;
        chk("rst.cnt",  32'(bus.cnt),  32'd2);
        chk("rst.tick", 32'(bus.tick), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.err",  32'(bus.err),  32'd0);
        @(negedge ck);
        #1;
        chk("rst.f", 32'(bus.f), 32'd0);

        foreach (vt[i]) begin
            apply_vec($sformatf("v%0d", i), vt[i]);
        end

        // Reset mid-period with a pending load: pending value is dropped and
        // the DIV_DEF=3 cadence restarts with a tick on the first edge.
        vt.delete();
        add(0, 1, 1, 4,   1, 0, 1, 0, 1, 1);
        add(1, 1, 1, 9,   2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0,   2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);
        foreach (vt[i]) begin
            apply_vec($sformatf("mrst%0d", i), vt[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
